// File: rtl/bresenham_line_engine_if.sv
// bresenham_line_engine_if: line request and pixel stream bundle (pix_count present with BRESENHAM_PIXEL_COUNT_EN)
interface bresenham_line_engine_if #(parameter int W = 10);
  logic draw;
  logic [W-1:0] x1;
  logic [W-1:0] y1;
  logic [W-1:0] x2;
  logic [W-1:0] y2;
  logic [W-1:0] x_out;
  logic [W-1:0] y_out;
  logic plot;
  logic busy;
  logic done;
`ifdef BRESENHAM_PIXEL_COUNT_EN
  logic [W:0] pix_count;
  modport master (output draw, x1, y1, x2, y2, input x_out, y_out, plot, busy, done, pix_count);
  modport slave (input draw, x1, y1, x2, y2, output x_out, y_out, plot, busy, done, pix_count);
`else
  modport master (output draw, x1, y1, x2, y2, input x_out, y_out, plot, busy, done);
  modport slave (input draw, x1, y1, x2, y2, output x_out, y_out, plot, busy, done);
`endif
endinterface

// File: rtl/bresenham_line_engine.sv
// bresenham_line_engine: one-pixel-per-clock Bresenham rasteriser, all octants (optional pix_count via BRESENHAM_PIXEL_COUNT_EN)
module bresenham_line_engine #(parameter int W = 10) (
  input logic clk,
  input logic reset,
  bresenham_line_engine_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [W-1:0] x_q, y_q, xe, ye, dx, dy, ldx, ldy;
  logic plot_q, busy_q, done_q, sxn, syn, stx, sty, at_end;
  logic signed [W+1:0] err, err_nx, dxw, dyw;
  logic signed [W+2:0] e2, dxe, dye;
  // step decisions from the current error term; diagonal steps combine both updates
  always_comb begin
    ldx = bus.x2 >= bus.x1 ? bus.x2 - bus.x1 : bus.x1 - bus.x2;
    ldy = bus.y2 >= bus.y1 ? bus.y2 - bus.y1 : bus.y1 - bus.y2;
    dxw = $signed({2'b00, dx});
    dyw = $signed({2'b00, dy});
    dxe = $signed({3'b000, dx});
    dye = $signed({3'b000, dy});
    e2 = {err, 1'b0};
    stx = e2 > -dye;
    sty = e2 < dxe;
    err_nx = err - (stx ? dyw : '0) + (sty ? dxw : '0);
    at_end = x_q == xe && y_q == ye;
  end
  // line FSM: load endpoints in IDLE, walk in RUN, wait for draw release in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      x_q <= '0;
      y_q <= '0;
      plot_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err <= '0;
    end else if (state == IDLE) begin
      if (bus.draw) begin
        xe <= bus.x2;
        ye <= bus.y2;
        dx <= ldx;
        dy <= ldy;
        sxn <= bus.x2 < bus.x1;
        syn <= bus.y2 < bus.y1;
        err <= $signed({2'b00, ldx}) - $signed({2'b00, ldy});
        x_q <= bus.x1;
        y_q <= bus.y1;
        plot_q <= 1'b1;
        busy_q <= 1'b1;
        state <= RUN;
      end
    end else if (state == RUN) begin
      if (at_end) begin
        plot_q <= 1'b0;
        busy_q <= 1'b0;
        done_q <= 1'b1;
        state <= DONE;
      end else begin
        err <= err_nx;
        x_q <= stx ? (sxn ? x_q - 1'b1 : x_q + 1'b1) : x_q;
        y_q <= sty ? (syn ? y_q - 1'b1 : y_q + 1'b1) : y_q;
      end
    end else begin
      done_q <= 1'b0;
      state <= bus.draw ? DONE : IDLE;
    end
  end
  assign bus.x_out = x_q;
  assign bus.y_out = y_q;
  assign bus.plot = plot_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef BRESENHAM_PIXEL_COUNT_EN
  logic [W:0] cnt;
  // pixel counter: cleared at load, counts every plotted cycle
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && bus.draw)) cnt <= '0;
    else if (plot_q) cnt <= cnt + 1'b1;
  end
  assign bus.pix_count = cnt;
`endif
endmodule

// File: tb/tb_bresenham_line_engine.sv
// tb_bresenham_line_engine: table-driven scoreboard bench for bresenham_line_engine
module tb_bresenham_line_engine;
  localparam int W = 10;
  typedef struct {int x1; int y1; int x2; int y2; int n;} vec_t;
  typedef struct {int x; int y;} pix_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  pix_t q[$];
  vec_t tv[9];
  bresenham_line_engine_if #(.W(W)) bi();
  bresenham_line_engine #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bi));
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model(input int x1, input int y1, input int x2, input int y2);
    int x = x1, y = y1, e2;
    int dx = x2 >= x1 ? x2 - x1 : x1 - x2;
    int dy = y2 >= y1 ? y2 - y1 : y1 - y2;
    int sx = x2 >= x1 ? 1 : -1;
    int sy = y2 >= y1 ? 1 : -1;
    int err = dx - dy;
    forever begin
      q.push_back('{x, y});
      if (x == x2 && y == y2) break;
      e2 = 2 * err;
      if (e2 > -dy) begin err -= dy; x += sx; end
      if (e2 < dx) begin err += dx; y += sy; end
    end
  endfunction

  task automatic start(input int x1, input int y1, input int x2, input int y2);
    @(negedge clk);
    bi.x1 = W'(x1);
    bi.y1 = W'(y1);
    bi.x2 = W'(x2);
    bi.y2 = W'(y2);
    bi.draw = 1'b1;
  endtask

  task automatic consume(input int n, input int ex, input int ey);
    int cnt = 0;
    bit fin = 0;
    pix_t p;
    for (int c = 0; c < 5000 && !fin; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bi.x1 = W'($urandom_range(0, 1023));
        bi.y1 = W'($urandom_range(0, 1023));
        bi.x2 = W'($urandom_range(0, 1023));
        bi.y2 = W'($urandom_range(0, 1023));
      end
      if (bi.plot) begin
        cnt++;
        check("busy_run", int'(bi.busy), 1);
        if (q.size() == 0) check("extra_pixel", cnt, n);
        else begin
          p = q.pop_front();
          check("x_out", int'(bi.x_out), p.x);
          check("y_out", int'(bi.y_out), p.y);
        end
      end else if (bi.done) fin = 1;
      else begin
        check("plot_dropped_before_done", int'(bi.plot), 1);
        fin = 1;
      end
    end
    check("line_finished_in_budget", int'(fin), 1);
    check("pixel_count", cnt, n);
    check("queue_drained", q.size(), 0);
    check("end_x", int'(bi.x_out), ex);
    check("end_y", int'(bi.y_out), ey);
    check("busy_at_done", int'(bi.busy), 0);
`ifdef BRESENHAM_PIXEL_COUNT_EN
    check("pix_count_at_done", int'(bi.pix_count), n);
`endif
    q.delete();
    @(negedge clk);
    check("done_one_cycle", int'(bi.done), 0);
    check("no_retrigger_plot", int'(bi.plot), 0);
    @(negedge clk);
    check("no_retrigger_plot2", int'(bi.plot), 0);
    check("hold_x", int'(bi.x_out), ex);
    bi.draw = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    tv[0] = '{5, 5, 13, 9, 9};
    tv[1] = '{1, 1, 5, 3, 5};
    tv[2] = '{9, 13, 5, 5, 9};
    tv[3] = '{3, 0, 3, 4, 5};
    tv[4] = '{7, 7, 7, 7, 1};
    tv[5] = '{13, 9, 5, 5, 9};
    tv[6] = '{2, 8, 6, 1, 8};
    tv[7] = '{0, 0, 1023, 1023, 1024};
    tv[8] = '{1023, 0, 0, 3, 1024};
    bi.draw = 1'b0;
    bi.x1 = '0;
    bi.y1 = '0;
    bi.x2 = '0;
    bi.y2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_x", int'(bi.x_out), 0);
    check("rst_y", int'(bi.y_out), 0);
    check("rst_plot", int'(bi.plot), 0);
    check("rst_busy", int'(bi.busy), 0);
    check("rst_done", int'(bi.done), 0);
`ifdef BRESENHAM_PIXEL_COUNT_EN
    check("rst_pix_count", int'(bi.pix_count), 0);
`endif
    q = '{'{5,5}, '{6,5}, '{7,6}, '{8,6}, '{9,7}, '{10,7}, '{11,8}, '{12,8}, '{13,9}};
    start(5, 5, 13, 9);
    consume(9, 13, 9);
    q = '{'{1,1}, '{2,1}, '{3,2}, '{4,2}, '{5,3}};
    start(1, 1, 5, 3);
    consume(5, 5, 3);
    start(5, 5, 13, 9);
    repeat (3) @(negedge clk);
    check("mid_third_x", int'(bi.x_out), 7);
    check("mid_third_y", int'(bi.y_out), 6);
    reset = 1'b1;
    bi.draw = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_x", int'(bi.x_out), 0);
    check("midrst_y", int'(bi.y_out), 0);
    check("midrst_plot", int'(bi.plot), 0);
    check("midrst_busy", int'(bi.busy), 0);
`ifdef BRESENHAM_PIXEL_COUNT_EN
    check("midrst_pix_count", int'(bi.pix_count), 0);
`endif
    @(negedge clk);
    check("midrst_no_pixels", int'(bi.plot), 0);
    for (int i = 0; i < 9; i++) begin
      model(tv[i].x1, tv[i].y1, tv[i].x2, tv[i].y2);
      start(tv[i].x1, tv[i].y1, tv[i].x2, tv[i].y2);
      consume(tv[i].n, tv[i].x2, tv[i].y2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
